// File: rtl/sha1_msg_sched.sv
// SHA-1 message-schedule generator: loads one 512-bit block and streams W[0..79]
// with the round index, using a 16-word sliding window.
module sha1_msg_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         flush,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [8:0]   t_out,
    output logic         w_last,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam logic [8:0] T_LAST = 9'd79;

    state_e      state_q;
    logic [31:0] win_q [16];
    logic [8:0]  t_q;
    logic [31:0] mix_d;
    logic [31:0] w_new_d;

    // W[t+16] from the taps at window offsets 13, 8, 2 and 0.
    assign mix_d   = win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0];
    assign w_new_d = {mix_d[30:0], mix_d[31]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (blk_valid && !flush) begin
                        for (int i = 0; i < 16; i++) begin
                            win_q[i] <= blk_data[511-32*i -: 32];
                        end
                        t_q     <= '0;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    // Flush wins over a coincident beat; window contents are left stale.
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (w_ready) begin
                        if (t_q == T_LAST) begin
                            state_q <= IDLE;
                        end else begin
                            for (int i = 0; i < 15; i++) begin
                                win_q[i] <= win_q[i+1];
                            end
                            win_q[15] <= w_new_d;
                            t_q       <= t_q + 9'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign blk_ready = (state_q == IDLE) && !flush;
    assign w_valid   = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign w_last    = (state_q == EMIT) && (t_q == T_LAST);
    assign w_out     = win_q[0];
    assign t_out     = t_q;

endmodule

// File: tb/tb_sha1_msg_sched.sv
// Self-checking bench for sha1_msg_sched: table vectors for the "abc" block plus
// random blocks against an array-based SHA-1 schedule model.
module tb_sha1_msg_sched;

    logic         clk;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         flush;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [8:0]   t_out;
    logic         w_last;
    logic         busy;

    sha1_msg_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .flush     (flush),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .t_out     (t_out),
        .w_last    (w_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] w;
    } vec_t;

    int          checks;
    int          errors;
    logic [31:0] exp_w [80];
    logic [31:0] cap_w [80];
    vec_t        abc_vec [5];
    logic [511:0] abc_blk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Textbook SHA-1 expansion on a flat 80-entry array.
    task automatic compute_model(input logic [511:0] b);
        logic [31:0] x;
        for (int i = 0; i < 16; i++) exp_w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            x = exp_w[i-3] ^ exp_w[i-8] ^ exp_w[i-14] ^ exp_w[i-16];
            exp_w[i] = (x << 1) | (x >> 31);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Presents blk, then consumes all 80 words with w_ready high rdy_pct% of cycles.
    // nxt_valid/nxt_blk is what the upstream drives while this block runs.
    task automatic run_block(input logic [511:0] blk, input int rdy_pct,
                             input logic nxt_valid, input logic [511:0] nxt_blk);
        int idx;
        int c;
        int stalls;
        logic rdy;
        compute_model(blk);
        blk_valid = 1'b1;
        blk_data  = blk;
        w_ready   = 1'b0;
        #1;
        chk("accept_ready", blk_ready, 1);
        tick();
        blk_valid = nxt_valid;
        blk_data  = nxt_blk;
        idx = 0;
        c = 1;
        stalls = 0;
        while (idx < 80 && c < 2000) begin
            rdy = ($urandom_range(99) < rdy_pct);
            w_ready = rdy;
            #1;
            chk("w_valid", w_valid, 1);
            chk("t_out", t_out, idx);
            chk("w_out", w_out, exp_w[idx]);
            chk("w_last", w_last, (idx == 79));
            chk("blk_ready_busy", blk_ready, 0);
            if (rdy) begin
                cap_w[idx] = w_out;
                idx++;
            end else begin
                stalls++;
            end
            tick();
            c++;
        end
        chk("block_timeout", (idx == 80), 1);
        w_ready = 1'b0;
        #1;
        chk("end_w_valid", w_valid, 0);
        chk("end_blk_ready", blk_ready, 1);
        chk("total_cycles", c, 81 + stalls);
    endtask

    // Accepts blk and beats with w_ready=1 until t_out == stop_t, returning in that cycle's sample slot.
    task automatic start_and_advance(input logic [511:0] blk, input int stop_t);
        int c;
        compute_model(blk);
        blk_valid = 1'b1;
        blk_data  = blk;
        w_ready   = 1'b1;
        #1;
        chk("adv_accept", blk_ready, 1);
        tick();
        blk_valid = 1'b0;
        c = 0;
        #1;
        while (t_out != 9'(stop_t) && c < 200) begin
            chk("adv_w_out", w_out, exp_w[t_out]);
            tick();
            #1;
            c++;
        end
        chk("adv_reach_t", t_out, stop_t);
        chk("adv_w_valid", w_valid, 1);
    endtask

    initial begin
        logic [511:0] r;
        checks = 0;
        errors = 0;
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        abc_vec[0] = '{0,  32'h61626380};
        abc_vec[1] = '{16, 32'hC2C4C700};
        abc_vec[2] = '{17, 32'h00000000};
        abc_vec[3] = '{18, 32'h00000030};
        abc_vec[4] = '{19, 32'h85898E01};

        rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; flush = 1'b0; w_ready = 1'b0;
        #1;
        chk("rst_blk_ready", blk_ready, 1);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_w_last", w_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_w_out", w_out, 0);
        chk("rst_t_out", t_out, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // "abc" block, full throughput
        run_block(abc_blk, 100, 1'b0, '0);
        for (int i = 0; i < 5; i++) chk("abc_vec", cap_w[abc_vec[i].idx], abc_vec[i].w);

        // Same block under 50% backpressure
        for (int i = 0; i < 80; i++) cap_w[i] = '0;
        run_block(abc_blk, 50, 1'b0, '0);
        for (int i = 0; i < 5; i++) chk("abc_bp_vec", cap_w[abc_vec[i].idx], abc_vec[i].w);

        // Reset mid-block at t = 37
        start_and_advance(abc_blk, 37);
        rst_n = 1'b0;
        #1;
        chk("midrst_w_valid", w_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_t_out", t_out, 0);
        chk("midrst_blk_ready", blk_ready, 1);
        chk("midrst_w_out", w_out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_block(rand_blk(), 100, 1'b0, '0);

        // Flush coincident with the t = 20 beat, then flush blocks acceptance in IDLE
        start_and_advance(abc_blk, 20);
        flush = 1'b1;
        tick();
        w_ready = 1'b0;
        #1;
        chk("flush_w_valid", w_valid, 0);
        chk("flush_busy", busy, 0);
        r = rand_blk();
        blk_valid = 1'b1;
        blk_data  = r;
        #1;
        chk("flush_idle_ready", blk_ready, 0);
        tick();
        chk("flush_not_accepted", busy, 0);
        flush = 1'b0;
        run_block(r, 100, 1'b0, '0);

        // Back-to-back: B held valid while A runs
        r = rand_blk();
        run_block(rand_blk(), 70, 1'b1, r);
        run_block(r, 100, 1'b0, '0);

        // Random full-schedule sweep
        for (int n = 0; n < 64; n++) begin
            run_block(rand_blk(), (n % 2 == 0) ? 100 : 50, 1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
